repeated_pattern_mas: RTL and testbench
=======================================

Name: repeated_pattern_mas

Overview:
Mask generator for a 640-column sensor array. It tiles a short user pattern of 5 to 8 bits across all 640 columns to form a column mask. The mask feeds the column-masking stage of the sensor readout path. The output is registered and updates on clock edges when the clock enable is asserted.

Parameters:
- NCOLS, 640, number of sensor columns (width of maskOut). The design is only required to work at the default value.
- PMAX, 8, maximum pattern width (width of p).

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst_n  input  1  asynchronous reset, active low.
- clk_en  input  1  clock enable; the mask register loads only when this is 1.
- pattern_w  input  2  pattern width code: 00=5, 01=6, 10=7, 11=8 bits.
- p  input  8  pattern bits. Only p[W-1:0] is used, where W = pattern_w + 5.
- maskOut  output  640  registered column mask; bit i drives column i.

Behaviour:
- Effective width: W = 5 + pattern_w, giving W in {5,6,7,8}.
- Bit mapping, LSB-first:
  - next_mask[i] = p[i mod W] for i = 0..639.
  - Column 0 takes p[0], column W-1 takes p[W-1], column W takes p[0] again, and so on.
- Bits p[7:W] are ignored. Changing them has no effect on maskOut.
- Wrap-around: 640 is not a multiple of 6 or 7, so the final repetition is truncated, not padded.
  - W=6: columns 636..639 = p[0..3].
  - W=7: columns 637..639 = p[0..2].
  - W=5 and W=8 tile exactly (128 and 80 repetitions).
- Generation is purely combinational from (pattern_w, p).
  - Implement with constant per-column modulo indices: each column is a 4:1 mux selecting among p[i%5], p[i%6], p[i%7], p[i%8] by pattern_w.
  - No arithmetic modulo in hardware.
- Register:
  - On a rising clk edge with clk_en=1, maskOut <= next_mask.
  - With clk_en=0, maskOut holds its value.
- Latency: one clock. Inputs present before rising edge k appear on maskOut after edge k.
- Reset:
  - rst_n=0 forces maskOut to all zeros immediately, independent of clk and clk_en.
  - While rst_n=0, maskOut stays all zeros.
  - The first load occurs on the first rising edge with rst_n=1 and clk_en=1.
  - Reset asserted mid-operation clears the mask at once. No other state exists.
- Input changes between edges do not affect maskOut until the next enabled edge.
- No handshake, no FSM, no X propagation from the unused p bits.

Test Plan:
- Reset: rst_n=0 with p=8'hFF, pattern_w=11, clk_en=1, several clocks -> maskOut = 640'h0 throughout. Release rst_n; after the next edge, maskOut = all ones.
- Width 8: pattern_w=11, p=8'b10101010, one edge -> maskOut = {80{8'hAA}}, i.e. 640 bits of hex A…A with bit 0 = 0.
- Width 6 with truncation: pattern_w=01, p=8'b00010101, one edge -> maskOut = {160{4'h5}} (even columns 1, odd columns 0). Check that bits 639..636 = 0101 and that p[7:6] are ignored.
- Width 5 and 7:
  - pattern_w=00, p=8'b111_10011 -> maskOut[4:0]=10011 repeated 128 times, upper p bits ignored.
  - pattern_w=10, p=8'b0_0000001 -> ones only at columns 0, 7, 14, …, 637; all others 0.
- Clock enable: load p=8'hAA with W=8, then set clk_en=0 and change p=8'h0F, pattern_w=00 for 3 edges -> maskOut unchanged. Set clk_en=1 -> the new mask appears after one edge.
- Async reset mid-run: with the mask nonzero, pulse rst_n low between clock edges -> maskOut = 0 immediately, before any clock edge.

Source files
------------

// File: rtl/repeated_pattern_mas.sv
// Column mask generator: tiles a 5..8-bit pattern LSB-first across all sensor
// columns and registers the result under a clock enable.
module repeated_pattern_mas #(
    parameter int unsigned NCOLS = 640,
    parameter int unsigned PMAX  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clk_en,
    input  logic [1:0]       pattern_w,
    input  logic [PMAX-1:0]  p,
    output logic [NCOLS-1:0] maskOut
);

    localparam int unsigned W5 = 5;
    localparam int unsigned W6 = 6;
    localparam int unsigned W7 = 7;
    localparam int unsigned W8 = 8;

    logic [NCOLS-1:0] mask_d;
    logic [NCOLS-1:0] mask_q;

    // Each column is a 4:1 mux over elaboration-time constant pattern indices.
    always_comb begin
        mask_d = '0;
        for (int unsigned i = 0; i < NCOLS; i++) begin
            unique case (pattern_w)
                2'b00:   mask_d[i] = p[i % W5];
                2'b01:   mask_d[i] = p[i % W6];
                2'b10:   mask_d[i] = p[i % W7];
                default: mask_d[i] = p[i % W8];
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mask_q <= '0;
        end else if (clk_en) begin
            mask_q <= mask_d;
        end
    end

    assign maskOut = mask_q;

endmodule

// File: tb/tb_repeated_pattern_mas.sv
// Directed bench for repeated_pattern_mas: hand-built expected masks checked
// with immediate assertions after each clock edge.
module tb_repeated_pattern_mas;

    logic         clk;
    logic         rst_n;
    logic         clk_en;
    logic [1:0]   pattern_w;
    logic [7:0]   p;
    logic [639:0] maskOut;

    int checks;
    int passed;

    repeated_pattern_mas dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .clk_en   (clk_en),
        .pattern_w(pattern_w),
        .p        (p),
        .maskOut  (maskOut)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [639:0] obs, input logic [639:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    initial begin
        logic [639:0] ones;
        logic [639:0] exp_aa;
        logic [639:0] exp_w6;
        logic [639:0] exp_w5;
        logic [639:0] exp_w5b;
        logic [643:0] tmp7;
        logic [639:0] exp_w7;
        logic [3:0]   top4;

        checks  = 0;
        passed  = 0;
        ones    = '1;
        exp_aa  = {80{8'hAA}};
        exp_w6  = {160{4'h5}};
        exp_w5  = {128{5'b10011}};
        exp_w5b = {128{5'b01111}};
        tmp7    = {92{7'b0000001}};
        exp_w7  = tmp7[639:0];

        // reset held with all-ones inputs
        rst_n = 1'b0; clk_en = 1'b1; pattern_w = 2'b11; p = 8'hFF;
        #2;
        check("reset_t0", maskOut, '0);
        step();
        check("reset_edge1", maskOut, '0);
        step(); step();
        check("reset_edge3", maskOut, '0);
        rst_n = 1'b1;
        step();
        check("first_load_ones", maskOut, ones);

        // width 8
        p = 8'b1010_1010;
        #1;
        check("no_change_before_edge", maskOut, ones);
        step();
        check("w8_aa", maskOut, exp_aa);

        // width 6 with truncation, upper bits ignored
        pattern_w = 2'b01; p = 8'b0001_0101;
        step();
        check("w6_alt", maskOut, exp_w6);
        top4 = maskOut[639:636];
        check("w6_top4", {636'd0, top4}, {636'd0, 4'b0101});
        p = 8'b1101_0101;
        step();
        check("w6_upper_ignored", maskOut, exp_w6);

        // width 5, upper bits ignored
        pattern_w = 2'b00; p = 8'b111_10011;
        step();
        check("w5_10011", maskOut, exp_w5);
        p = 8'b000_10011;
        step();
        check("w5_upper_ignored", maskOut, exp_w5);

        // width 7 single one
        pattern_w = 2'b10; p = 8'b0_0000001;
        step();
        check("w7_every7", maskOut, exp_w7);
        check("w7_col637", {639'd0, maskOut[637]}, 640'd1);

        // clock enable hold
        pattern_w = 2'b11; p = 8'hAA;
        step();
        check("ce_load_aa", maskOut, exp_aa);
        clk_en = 1'b0; p = 8'h0F; pattern_w = 2'b00;
        for (int k = 0; k < 3; k++) begin
            step();
            check("ce_hold", maskOut, exp_aa);
        end
        clk_en = 1'b1;
        step();
        check("ce_reload_w5", maskOut, exp_w5b);

        // asynchronous reset between edges
        rst_n = 1'b0;
        #1;
        check("async_reset_immediate", maskOut, '0);
        step();
        check("async_reset_held", maskOut, '0);
        rst_n = 1'b1;
        step();
        check("after_async_reload", maskOut, exp_w5b);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
